// File: rtl/button_repeat_ctrl.sv
// Turns four debounced button levels into move events: one on press, one after a
// hold delay, then one per repeat period while held. Only one button is active at a time.
module button_repeat_ctrl #(
  parameter int c_REPEAT_DELAY  = 12500000,
  parameter int c_REPEAT_PERIOD = 5000000,
  parameter int c_CNT_WIDTH     = 24
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Switch,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic       o_Held
);

  // state      | meaning
  // IDLE       | no button active, waiting for a rising edge
  // HOLD_DELAY | active button pressed, timing the initial hold delay
  // REPEAT     | active button held past the delay, emitting periodic events
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_DELAY = 2'd1,
    REPEAT     = 2'd2
  } state_t;

  localparam logic [c_CNT_WIDTH-1:0] DelayLast  = c_CNT_WIDTH'(c_REPEAT_DELAY - 1);
  localparam logic [c_CNT_WIDTH-1:0] PeriodLast = c_CNT_WIDTH'(c_REPEAT_PERIOD - 1);

  state_t                 state, state_nxt;
  logic [c_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [1:0]             active, active_nxt;
  logic [1:0]             dir_nxt;
  logic                   pulse;
  logic [3:0]             prev;
  logic [3:0]             rise;
  logic                   any_rise;
  logic [1:0]             win;
  logic                   active_level;
  logic                   take_new;

  assign rise         = i_Switch & ~prev;
  assign any_rise     = |rise;
  assign active_level = i_Switch[active];

  // Lowest rising index wins; higher simultaneous rises are dropped.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) win = 2'(i);
    end
  end

  // A new button is taken from IDLE, or when the active one lets go in the same cycle.
  assign take_new = any_rise && ((state == IDLE) || !active_level);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    active_nxt = active;
    dir_nxt    = o_Move_Dir;
    pulse      = 1'b0;
    if (take_new) begin
      state_nxt  = HOLD_DELAY;
      cnt_nxt    = '0;
      active_nxt = win;
      dir_nxt    = win;
      pulse      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
        end
        HOLD_DELAY: begin
          if (!active_level) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DelayLast) begin
            state_nxt = REPEAT;
            cnt_nxt   = '0;
            pulse     = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!active_level) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == PeriodLast) begin
            cnt_nxt = '0;
            pulse   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Prev resets to all-ones so buttons held through reset need a fresh press.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= IDLE;
      cnt          <= '0;
      active       <= 2'd0;
      prev         <= 4'b1111;
      o_Move_Valid <= 1'b0;
      o_Move_Dir   <= 2'd0;
      o_Held       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      active       <= active_nxt;
      prev         <= i_Switch;
      o_Move_Valid <= pulse;
      o_Move_Dir   <= dir_nxt;
      o_Held       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Bench for button_repeat_ctrl: directed scenarios plus random button patterns,
// checked every cycle against a press-time based reference model.
module tb_button_repeat_ctrl;

  localparam int DELAY  = 8;
  localparam int PERIOD = 4;

  logic       clk_sys;
  logic       rst;
  logic [3:0] sw;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       held;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: remembers which button is active and the cycle it was pressed;
  // events fall at press time, press+DELAY, then every PERIOD.
  bit         m_on;
  int         m_act;
  int         m_t0;
  logic [3:0] m_prev;
  logic       m_valid;
  logic [1:0] m_dir;
  logic       m_held;

  button_repeat_ctrl #(
    .c_REPEAT_DELAY (DELAY),
    .c_REPEAT_PERIOD(PERIOD),
    .c_CNT_WIDTH    (4)
  ) dut (
    .i_Clk       (clk_sys),
    .i_Rst       (rst),
    .i_Switch    (sw),
    .o_Move_Valid(move_valid),
    .o_Move_Dir  (move_dir),
    .o_Held      (held)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    int el;
    if (rst) begin
      m_on = 0; m_act = 0; m_prev = 4'hF;
      m_valid = 1'b0; m_dir = 2'd0; m_held = 1'b0;
    end else begin
      rise    = sw & ~m_prev;
      m_valid = 1'b0;
      if (m_on && !sw[m_act]) m_on = 0;
      if (m_on) begin
        el = cyc - m_t0;
        if (el >= DELAY && ((el - DELAY) % PERIOD) == 0) m_valid = 1'b1;
      end else if (rise != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (rise[i]) m_act = i;
        m_on    = 1;
        m_t0    = cyc;
        m_valid = 1'b1;
        m_dir   = 2'(m_act);
      end
      m_held = m_on;
      m_prev = sw;
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    chk("valid", 32'(move_valid), 32'(m_valid));
    chk("dir",   32'(move_dir),   32'(m_dir));
    chk("held",  32'(held),       32'(m_held));
    cyc++;
  endtask

  task automatic drive(input logic [3:0] s, input logic r, input int n);
    sw  = s;
    rst = r;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    sw  = 4'b0001;
    rst = 1'b1;
    // 1: held through reset stays silent until re-pressed
    drive(4'b0001, 1'b1, 3);
    drive(4'b0001, 1'b0, 30);
    drive(4'b0000, 1'b0, 2);
    drive(4'b0001, 1'b0, 3);
    drive(4'b0000, 1'b0, 2);
    // 2: long hold of left
    drive(4'b0100, 1'b0, 30);
    drive(4'b0000, 1'b0, 5);
    // 3: short press of right
    drive(4'b1000, 1'b0, 5);
    drive(4'b0000, 1'b0, 12);
    // 4: simultaneous rise, ignored rise, release leaves other held
    drive(4'b1010, 1'b0, 5);
    drive(4'b1011, 1'b0, 5);
    drive(4'b1001, 1'b0, 5);
    drive(4'b0000, 1'b0, 3);
    // 5: hand-over from down to left in the same cycle
    drive(4'b0010, 1'b0, 10);
    drive(4'b0100, 1'b0, 20);
    drive(4'b0000, 1'b0, 3);
    // 6: reset on the edge a repeat event is due
    drive(4'b0001, 1'b0, 12);
    drive(4'b0001, 1'b1, 2);
    drive(4'b0001, 1'b0, 20);
    drive(4'b0000, 1'b0, 2);
    drive(4'b0001, 1'b0, 14);
    drive(4'b0000, 1'b0, 2);
    // random segments
    for (int s = 0; s < 250; s++) begin
      logic [3:0] pat;
      logic       r;
      if ($urandom_range(0, 1) == 0) pat = 4'(1 << $urandom_range(0, 3));
      else                           pat = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 39) == 0);
      drive(pat, r, r ? $urandom_range(1, 3) : $urandom_range(1, 22));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
